// File: rtl/ofs_plat_utils_avalon_mm_split_pkg.sv
// Shared types for the Avalon-MM burst splitter.
// FSM state encoding and Avalon response codes.
package ofs_plat_utils_avalon_mm_split_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_SPLIT = 2'd1,
        WR_BURST = 2'd2
    } t_split_state;

    localparam logic [1:0] RSP_OKAY   = 2'b00;
    localparam logic [1:0] RSP_SLVERR = 2'b10;
    localparam logic [1:0] RSP_DECERR = 2'b11;

endpackage

// File: rtl/ofs_plat_utils_avalon_mm_wr_rsp_tracker.sv
// One-bit flag FIFO, first-word-fall-through, one entry per m0 write
// sub-burst; the flag marks the final sub-burst of an s0 burst.
module ofs_plat_utils_avalon_mm_wr_rsp_tracker #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic push_flag_i,
    input  logic pop_i,
    output logic flag_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign flag_o  = mem_q[rd_ptr_q];

    // Flag storage; entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_flag_i;
        end
    end

    // Pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ofs_plat_utils_avalon_mm_burst_splitter.sv
// Avalon-MM burst splitter: cuts s0 bursts into m0 sub-bursts of at most
// S beats and merges the split write responses back per s0 burst.
module ofs_plat_utils_avalon_mm_burst_splitter
    import ofs_plat_utils_avalon_mm_split_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int SYMBOL_WIDTH       = 8,
    parameter int RESPONSE_WIDTH     = 2,
    parameter int HDL_ADDR_WIDTH     = 10,
    parameter int BURSTCOUNT_WIDTH   = 7,
    parameter int M_BURSTCOUNT_WIDTH = 3,
    parameter int USE_WRITERESPONSE  = 0,
    parameter int WR_TRACK_DEPTH     = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,

    output logic                                   s0_waitrequest,
    output logic [DATA_WIDTH-1:0]                  s0_readdata,
    output logic                                   s0_readdatavalid,
    output logic                                   s0_writeresponsevalid,
    output logic [RESPONSE_WIDTH-1:0]              s0_response,
    input  logic [BURSTCOUNT_WIDTH-1:0]            s0_burstcount,
    input  logic [DATA_WIDTH-1:0]                  s0_writedata,
    input  logic [HDL_ADDR_WIDTH-1:0]              s0_address,
    input  logic [DATA_WIDTH/SYMBOL_WIDTH-1:0]     s0_byteenable,
    input  logic                                   s0_write,
    input  logic                                   s0_read,
    input  logic                                   s0_debugaccess,

    input  logic                                   m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]                  m0_readdata,
    input  logic                                   m0_readdatavalid,
    input  logic                                   m0_writeresponsevalid,
    input  logic [RESPONSE_WIDTH-1:0]              m0_response,
    output logic [M_BURSTCOUNT_WIDTH-1:0]          m0_burstcount,
    output logic [DATA_WIDTH-1:0]                  m0_writedata,
    output logic [HDL_ADDR_WIDTH-1:0]              m0_address,
    output logic [DATA_WIDTH/SYMBOL_WIDTH-1:0]     m0_byteenable,
    output logic                                   m0_write,
    output logic                                   m0_read,
    output logic                                   m0_debugaccess
);

    localparam int BCW = BURSTCOUNT_WIDTH;
    localparam int AW  = HDL_ADDR_WIDTH;
    localparam int RW  = RESPONSE_WIDTH;
    localparam logic USE_WR = (USE_WRITERESPONSE != 0);
    localparam logic [BCW-1:0] S_BEATS = BCW'(1 << (M_BURSTCOUNT_WIDTH - 1));

    t_split_state   state_q;
    logic [BCW-1:0] off_q;
    logic [BCW-1:0] idx_q;
    logic [BCW-1:0] blen_q;
    logic [AW-1:0]  base_q;
    logic [RW-1:0]  worst_q;
    logic [RW-1:0]  worst_d;
    logic [RW-1:0]  rsp_code_q;
    logic           rsp_valid_q;

    logic           in_rd;
    logic           in_wr;
    logic           is_rd;
    logic           is_wr;
    logic [BCW-1:0] cnt;
    logic [BCW-1:0] blen;
    logic [AW-1:0]  base;
    logic [BCW-1:0] rem;
    logic [BCW-1:0] piece_bc;
    logic           last_piece;
    logic           hdr;
    logic           trk_stall;
    logic           wr_acc;
    logic           rd_acc;
    logic           wr_last_beat;
    logic           push_last;

    logic           trk_push;
    logic           trk_pop;
    logic           trk_flag;
    logic           trk_full;
    logic           trk_empty;

    // Command decode: one counter serves both the read split and the
    // write beat index, selected by the current state
    always_comb begin
        in_rd      = (state_q == RD_SPLIT);
        in_wr      = (state_q == WR_BURST);
        is_wr      = s0_write & ~in_rd;
        is_rd      = s0_read & ~is_wr & ~in_wr;
        cnt        = in_wr ? idx_q : (in_rd ? off_q : '0);
        blen       = in_wr ? blen_q : s0_burstcount;
        base       = in_wr ? base_q : s0_address;
        rem        = blen - cnt;
        last_piece = (rem <= S_BEATS);
        piece_bc   = last_piece ? rem : S_BEATS;
        hdr        = ((cnt & (S_BEATS - 1'b1)) == '0);
        trk_stall  = USE_WR & hdr & trk_full;
        wr_last_beat = (cnt == blen - 1'b1);
        push_last  = ({1'b0, cnt} + {1'b0, S_BEATS}) >= {1'b0, blen};
        wr_acc     = ~reset & is_wr & ~trk_stall & ~m0_waitrequest;
        rd_acc     = ~reset & is_rd & ~m0_waitrequest;
    end

    assign m0_read        = ~reset & is_rd;
    assign m0_write       = ~reset & is_wr & ~trk_stall;
    assign m0_address     = base + AW'(cnt);
    assign m0_burstcount  = M_BURSTCOUNT_WIDTH'(piece_bc);
    assign m0_writedata   = s0_writedata;
    assign m0_byteenable  = s0_byteenable;
    assign m0_debugaccess = s0_debugaccess;

    assign s0_waitrequest = reset | m0_waitrequest
                          | (is_wr & trk_stall)
                          | (is_rd & ~last_piece);

    assign s0_readdata           = m0_readdata;
    assign s0_readdatavalid      = m0_readdatavalid;
    assign s0_writeresponsevalid = rsp_valid_q;
    assign s0_response           = rsp_valid_q ? rsp_code_q : m0_response;

    // Burst FSM with the read offset and write beat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            off_q   <= '0;
            idx_q   <= '0;
            blen_q  <= '0;
            base_q  <= '0;
        end else if (wr_acc) begin
            if (state_q == IDLE) begin
                base_q <= s0_address;
                blen_q <= s0_burstcount;
            end
            if (wr_last_beat) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else begin
                state_q <= WR_BURST;
                idx_q   <= cnt + 1'b1;
            end
        end else if (rd_acc) begin
            if (last_piece) begin
                state_q <= IDLE;
                off_q   <= '0;
            end else begin
                state_q <= RD_SPLIT;
                off_q   <= cnt + S_BEATS;
            end
        end
    end

    assign trk_push = USE_WR & wr_acc & hdr;
    assign trk_pop  = USE_WR & m0_writeresponsevalid & ~trk_empty;

    ofs_plat_utils_avalon_mm_wr_rsp_tracker #(
        .DEPTH(WR_TRACK_DEPTH)
    ) u_trk (
        .clk         (clk),
        .reset       (reset),
        .push_i      (trk_push),
        .push_flag_i (push_last),
        .pop_i       (trk_pop),
        .flag_o      (trk_flag),
        .full_o      (trk_full),
        .empty_o     (trk_empty)
    );

    // Worst-case response folding; higher code is more severe
    always_comb begin
        worst_d = (m0_response > worst_q) ? m0_response : worst_q;
    end

    // Emit one merged response after the last sub-burst's response
    always_ff @(posedge clk) begin
        if (reset) begin
            worst_q     <= '0;
            rsp_code_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (trk_pop) begin
                if (trk_flag) begin
                    rsp_valid_q <= 1'b1;
                    rsp_code_q  <= worst_d;
                    worst_q     <= '0;
                end else begin
                    worst_q <= worst_d;
                end
            end
        end
    end

    a_rw_excl: assert property (@(posedge clk) disable iff (reset)
        !(s0_read && s0_write));

    a_stale_rsp: assert property (@(posedge clk) disable iff (reset)
        !(USE_WR && m0_writeresponsevalid && trk_empty));

endmodule

// File: tb/tb_ofs_plat_utils_avalon_mm_burst_splitter.sv
// Bench for the Avalon-MM burst splitter (S=4, tracker depth 2).
// Vector table plus hand sequences; m0 side modelled as a simple slave.
module tb_ofs_plat_utils_avalon_mm_burst_splitter;
    import ofs_plat_utils_avalon_mm_split_pkg::*;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        s0_waitrequest;
    logic [31:0] s0_readdata;
    logic        s0_readdatavalid;
    logic        s0_writeresponsevalid;
    logic [1:0]  s0_response;
    logic [6:0]  s0_burstcount;
    logic [31:0] s0_writedata;
    logic [9:0]  s0_address;
    logic [3:0]  s0_byteenable;
    logic        s0_write;
    logic        s0_read;
    logic        s0_debugaccess;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic        m0_writeresponsevalid;
    logic [1:0]  m0_response;
    logic [2:0]  m0_burstcount;
    logic [31:0] m0_writedata;
    logic [9:0]  m0_address;
    logic [3:0]  m0_byteenable;
    logic        m0_write;
    logic        m0_read;
    logic        m0_debugaccess;

    ofs_plat_utils_avalon_mm_burst_splitter #(
        .DATA_WIDTH(32), .SYMBOL_WIDTH(8), .RESPONSE_WIDTH(2),
        .HDL_ADDR_WIDTH(10), .BURSTCOUNT_WIDTH(7),
        .M_BURSTCOUNT_WIDTH(3), .USE_WRITERESPONSE(1),
        .WR_TRACK_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s0_writeresponsevalid(s0_writeresponsevalid),
        .s0_response(s0_response), .s0_burstcount(s0_burstcount),
        .s0_writedata(s0_writedata), .s0_address(s0_address),
        .s0_byteenable(s0_byteenable), .s0_write(s0_write),
        .s0_read(s0_read), .s0_debugaccess(s0_debugaccess),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m0_writeresponsevalid(m0_writeresponsevalid),
        .m0_response(m0_response), .m0_burstcount(m0_burstcount),
        .m0_writedata(m0_writedata), .m0_address(m0_address),
        .m0_byteenable(m0_byteenable), .m0_write(m0_write),
        .m0_read(m0_read), .m0_debugaccess(m0_debugaccess)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [9:0] addr;
        logic [2:0] bc;
    } cmd_t;

    typedef struct {
        bit         wr;
        logic [9:0] addr;
        int         b;
        int         ncmd;
        int         err_piece;
        logic [1:0] err_code;
        logic [1:0] exp_code;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int ncmd  = 0;
    int wbeats = 0;
    int wr_rem = 0;
    bit rsp_en = 1'b1;
    bit rand_wait = 1'b0;
    bit stall_prev = 1'b0;
    cmd_t st_cmd;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wdata[$];
    logic [1:0]  exp_rsp[$];
    logic [1:0]  plan_codes[$];
    logic [1:0]  pend[$];
    logic [9:0]  rd_pend[$];

    vec_t vecs [12];

    function automatic logic [31:0] pat(input logic [9:0] a);
        return {22'h2A5A5A, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // m0 slave: random waitrequest when enabled
    always @(negedge clk) begin
        m0_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // m0 slave: read data and write responses
    always @(negedge clk) begin
        m0_readdatavalid      = 1'b0;
        m0_writeresponsevalid = 1'b0;
        m0_response           = 2'b00;
        if (rd_pend.size() > 0) begin
            m0_readdatavalid = 1'b1;
            m0_readdata      = pat(rd_pend.pop_front());
        end
        if (rsp_en && pend.size() > 0) begin
            m0_writeresponsevalid = 1'b1;
            m0_response           = pend.pop_front();
        end
    end

    // Monitor: samples just before each rising edge
    always @(negedge clk) begin
        cmd_t c;
        #3;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_rw", {m0_write, m0_read},
                      {st_cmd.wr, ~st_cmd.wr});
                check("stall_hold_addr", m0_address, st_cmd.addr);
                check("stall_hold_bc", m0_burstcount, st_cmd.bc);
            end
            stall_prev = (m0_read | m0_write) & m0_waitrequest;
            st_cmd = '{m0_write, m0_address, m0_burstcount};
            if (m0_read && !m0_waitrequest) begin
                ncmd++;
                if (exp_cmd.size() == 0) begin
                    fail_now("extra_m0_read");
                end else begin
                    c = exp_cmd.pop_front();
                    check("rd_cmd_type", m0_write, c.wr);
                    check("rd_cmd_addr", m0_address, c.addr);
                    check("rd_cmd_bc", m0_burstcount, c.bc);
                end
                for (int k = 0; k < int'(m0_burstcount); k++)
                    rd_pend.push_back(m0_address + 10'(k));
            end
            if (m0_write && !m0_waitrequest) begin
                wbeats++;
                if (wr_rem == 0) begin
                    ncmd++;
                    if (exp_cmd.size() == 0) begin
                        fail_now("extra_m0_write");
                    end else begin
                        c = exp_cmd.pop_front();
                        check("wr_cmd_type", m0_write, c.wr);
                        check("wr_cmd_addr", m0_address, c.addr);
                        check("wr_cmd_bc", m0_burstcount, c.bc);
                    end
                    wr_rem = int'(m0_burstcount);
                    pend.push_back(plan_codes.size() > 0 ?
                                   plan_codes.pop_front() : RSP_OKAY);
                end
                wr_rem--;
                if (exp_wdata.size() == 0)
                    fail_now("extra_wdata");
                else
                    check("wdata", m0_writedata, exp_wdata.pop_front());
            end
            if (s0_readdatavalid) begin
                if (exp_rd.size() == 0)
                    fail_now("extra_rdata");
                else
                    check("rdata", s0_readdata, exp_rd.pop_front());
            end
            if (s0_writeresponsevalid) begin
                if (exp_rsp.size() == 0)
                    fail_now("extra_wrsp");
                else
                    check("wrsp_code", s0_response, exp_rsp.pop_front());
            end
        end
    end

    task automatic push_cmds(input bit wr, input logic [9:0] a, input int b);
        cmd_t c;
        for (int o = 0; o < b; o += S) begin
            c.wr   = wr;
            c.addr = a + 10'(o);
            c.bc   = 3'((b - o) < S ? (b - o) : S);
            exp_cmd.push_back(c);
        end
    endtask

    // Called at a falling edge right after driving; returns at the
    // falling edge following the accepting rising edge
    task automatic s0_wait_accept(input string name);
        int n = 0;
        #3;
        while (s0_waitrequest && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 200) fail_now({name, "_timeout"});
        @(negedge clk);
    endtask

    task automatic do_read(input logic [9:0] a, input int b);
        push_cmds(1'b0, a, b);
        for (int i = 0; i < b; i++) exp_rd.push_back(pat(a + 10'(i)));
        s0_read       = 1'b1;
        s0_address    = a;
        s0_burstcount = 7'(b);
        s0_wait_accept("rd_accept");
        s0_read = 1'b0;
    endtask

    task automatic do_write(input logic [9:0] a, input int b);
        logic [31:0] d;
        push_cmds(1'b1, a, b);
        for (int i = 0; i < b; i++) begin
            d = $urandom;
            exp_wdata.push_back(d);
            s0_write      = 1'b1;
            s0_address    = (i == 0) ? a : 10'($urandom);
            s0_burstcount = 7'(b);
            s0_writedata  = d;
            s0_byteenable = 4'hF;
            s0_wait_accept("wr_accept");
        end
        s0_write = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rd.size() + exp_rsp.size() + pend.size()
                + rd_pend.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now({name, "_drain_timeout"});
        repeat (3) @(negedge clk);
        check({name, "_cmds_left"}, exp_cmd.size(), 0);
        check({name, "_wdata_left"}, exp_wdata.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        string nm;
        nm = $sformatf("vec%0d", id);
        ncmd = 0;
        if (v.wr) begin
            for (int p = 0; p < v.ncmd; p++)
                plan_codes.push_back(p == v.err_piece ? v.err_code : RSP_OKAY);
            exp_rsp.push_back(v.exp_code);
            do_write(v.addr, v.b);
        end else begin
            do_read(v.addr, v.b);
        end
        drain(nm);
        check({nm, "_ncmd"}, ncmd, v.ncmd);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 10'h020,  6,  2, -1, RSP_OKAY,   RSP_OKAY};
        vecs[1]  = '{1'b1, 10'h040,  8,  2,  1, RSP_SLVERR, RSP_SLVERR};
        vecs[2]  = '{1'b1, 10'h060,  4,  1, -1, RSP_OKAY,   RSP_OKAY};
        vecs[3]  = '{1'b0, 10'h3FE,  3,  1, -1, RSP_OKAY,   RSP_OKAY};
        vecs[4]  = '{1'b0, 10'h3FC,  9,  3, -1, RSP_OKAY,   RSP_OKAY};
        vecs[5]  = '{1'b1, 10'h3FE,  7,  2,  0, RSP_DECERR, RSP_DECERR};
        vecs[6]  = '{1'b0, 10'h007,  1,  1, -1, RSP_OKAY,   RSP_OKAY};
        vecs[7]  = '{1'b1, 10'h009,  1,  1,  0, RSP_SLVERR, RSP_SLVERR};
        vecs[8]  = '{1'b0, 10'h200, 64, 16, -1, RSP_OKAY,   RSP_OKAY};
        vecs[9]  = '{1'b1, 10'h300, 64, 16, 15, RSP_SLVERR, RSP_SLVERR};
        vecs[10] = '{1'b0, 10'h010,  5,  2, -1, RSP_OKAY,   RSP_OKAY};
        vecs[11] = '{1'b1, 10'h0A0,  5,  2,  1, RSP_DECERR, RSP_DECERR};

        reset          = 1'b1;
        s0_read        = 1'b1;
        s0_write       = 1'b0;
        s0_address     = 10'h100;
        s0_burstcount  = 7'd2;
        s0_writedata   = '0;
        s0_byteenable  = 4'hF;
        s0_debugaccess = 1'b0;

        // Reset state, with a read request held on s0
        repeat (3) @(negedge clk);
        #3;
        check("rst_m0_read", m0_read, 1'b0);
        check("rst_m0_write", m0_write, 1'b0);
        check("rst_s0_waitreq", s0_waitrequest, 1'b1);
        check("rst_s0_wrspvalid", s0_writeresponsevalid, 1'b0);
        @(negedge clk);
        s0_read = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        #3;
        check("idle_s0_waitreq", s0_waitrequest, 1'b0);
        @(negedge clk);

        // Read B=10 at 0x100: s0 retires only on the third piece
        ncmd = 0;
        push_cmds(1'b0, 10'h100, 10);
        for (int i = 0; i < 10; i++) exp_rd.push_back(pat(10'h100 + 10'(i)));
        s0_read       = 1'b1;
        s0_address    = 10'h100;
        s0_burstcount = 7'd10;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #3;
            check($sformatf("rd10_waitreq_c%0d", cyc + 1), s0_waitrequest,
                  cyc < 2);
            @(negedge clk);
        end
        s0_read = 1'b0;
        drain("rd10");
        check("rd10_ncmd", ncmd, 3);

        // Table vectors
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Tracker full: B=12 write with responses withheld stalls beat 8
        rsp_en = 1'b0;
        ncmd   = 0;
        wbeats = 0;
        plan_codes.push_back(RSP_OKAY);
        plan_codes.push_back(RSP_SLVERR);
        plan_codes.push_back(RSP_OKAY);
        exp_rsp.push_back(RSP_SLVERR);
        fork
            do_write(10'h080, 12);
            begin
                repeat (20) @(negedge clk);
                #3;
                check("full_beats", wbeats, 8);
                check("full_s0_waitreq", s0_waitrequest, 1'b1);
                check("full_m0_write", m0_write, 1'b0);
                rsp_en = 1'b1;
            end
        join
        drain("full");
        check("full_ncmd", ncmd, 3);
        check("full_total_beats", wbeats, 12);

        // Random m0 waitrequest on read B=9
        rand_wait = 1'b1;
        ncmd = 0;
        do_read(10'h050, 9);
        rand_wait = 1'b0;
        drain("rnd");
        check("rnd_ncmd", ncmd, 3);

        // Reset at beat 3 of a B=8 write
        rsp_en = 1'b0;
        push_cmds(1'b1, 10'h0C0, 8);
        for (int i = 0; i < 3; i++) begin
            exp_wdata.push_back(32'h1000 + 32'(i));
            s0_write      = 1'b1;
            s0_address    = 10'h0C0;
            s0_burstcount = 7'd8;
            s0_writedata  = 32'h1000 + 32'(i);
            s0_wait_accept("mrst_accept");
        end
        s0_writedata = 32'h1003;
        reset = 1'b1;
        #3;
        check("mrst_m0_write", m0_write, 1'b0);
        check("mrst_s0_waitreq", s0_waitrequest, 1'b1);
        @(negedge clk);
        #3;
        check("mrst_m0_write_n", m0_write, 1'b0);
        check("mrst_s0_waitreq_n", s0_waitrequest, 1'b1);
        check("mrst_wrspvalid", s0_writeresponsevalid, 1'b0);
        @(negedge clk);
        s0_write = 1'b0;
        reset    = 1'b0;
        exp_cmd.delete();
        exp_wdata.delete();
        pend.delete();
        plan_codes.delete();
        wr_rem = 0;
        rsp_en = 1'b1;
        @(negedge clk);
        ncmd = 0;
        plan_codes.push_back(RSP_OKAY);
        exp_rsp.push_back(RSP_OKAY);
        do_write(10'h0E0, 2);
        drain("post_rst");
        check("post_rst_ncmd", ncmd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
